// File: rtl/mac1d_inv_if.sv
// Operand/result handshake bundle for mac1d_inv: operands m, b, y in; x and
// status flags out, each side with its own valid/ready pair.
interface mac1d_inv_if #(
    parameter int IW_M = 4, parameter int QW_M = 8,
    parameter int IW_X = 4, parameter int QW_X = 8,
    parameter int IW_B = 4, parameter int QW_B = 8,
    parameter int IW_Y = 4, parameter int QW_Y = 8
);
    logic                  in_valid;
    logic                  in_ready;
    logic [IW_M+QW_M-1:0]  m;
    logic [IW_B+QW_B-1:0]  b;
    logic [IW_Y+QW_Y-1:0]  y;
    logic                  out_valid;
    logic                  out_ready;
    logic [IW_X+QW_X-1:0]  x;
    logic                  div_by_zero;
    logic                  saturated;

    modport slave (
        input  in_valid, m, b, y, out_ready,
        output in_ready, out_valid, x, div_by_zero, saturated
    );
    modport master (
        output in_valid, m, b, y, out_ready,
        input  in_ready, out_valid, x, div_by_zero, saturated
    );
endinterface

// File: rtl/mac1d_inv.sv
// Solves y = m*x + b for x = (y - b) / m with a bit-serial restoring divider.
// Define MAC1D_INV_ROUND_EN for round-to-nearest (ties away) with one extra guard cycle.
module mac1d_inv #(
    parameter int IW_M = 4, parameter int QW_M = 8,
    parameter int IW_X = 4, parameter int QW_X = 8,
    parameter int IW_B = 4, parameter int QW_B = 8,
    parameter int IW_Y = 4, parameter int QW_Y = 8
) (
    input  logic           clk_in,
    input  logic           rst_in,
    mac1d_inv_if.slave     bus
);
    localparam int MW = IW_M + QW_M;
    localparam int XW = IW_X + QW_X;
    localparam int BW = IW_B + QW_B;
    localparam int YW = IW_Y + QW_Y;
    localparam int DI = ((IW_Y > IW_B) ? IW_Y : IW_B) + 1;
    localparam int DQ = (QW_Y > QW_B) ? QW_Y : QW_B;
    localparam int DW = DI + DQ;
`ifdef MAC1D_INV_ROUND_EN
    localparam int GB = 1;
`else
    localparam int GB = 0;
`endif
    localparam int QB = XW + GB;
    localparam int NW = DW + QW_X + QW_M + GB;
    localparam int RW = NW + MW + DQ + QB;
    localparam int CW = $clog2(QB + 1);

    localparam logic [XW-1:0] XMAX = {1'b0, {(XW-1){1'b1}}};
    localparam logic [XW-1:0] XMIN = {1'b1, {(XW-1){1'b0}}};
    localparam logic [XW:0]   HALF = {2'b01, {(XW-1){1'b0}}};
    localparam logic [XW:0]   PLIM = HALF - {{XW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, LOAD, DIV, DONE} state_t;

    state_t               state;
    logic signed [MW-1:0] m_r;
    logic signed [BW-1:0] b_r;
    logic signed [YW-1:0] y_r;
    logic [RW-1:0]        rem, dsh;
    logic [QB-1:0]        q;
    logic [CW-1:0]        cnt;
    logic                 neg_r, ovf_r;
    logic                 rdy, ovld, dz_r, sat_r;
    logic [XW-1:0]        x_r;

    // Both operands are brought to DQ fraction bits; DI integer bits keep y-b exact.
    logic signed [DW-1:0] ya, ba, diff;
    logic [DW-1:0]        dmag;
    logic [MW-1:0]        mmag;
    logic [RW-1:0]        n_full, d_full;
    logic                 ovf;

    assign ya     = DW'(y_r) <<< (DQ - QW_Y);
    assign ba     = DW'(b_r) <<< (DQ - QW_B);
    assign diff   = ya - ba;
    assign dmag   = diff[DW-1] ? DW'(-diff) : DW'(diff);
    assign mmag   = m_r[MW-1] ? MW'(-m_r) : MW'(m_r);
    // Quotient |diff|/|m| scaled to QW_X (+guard) fraction bits, kept integral.
    assign n_full = RW'(dmag) << (QW_X + QW_M + GB);
    assign d_full = RW'(mmag) << DQ;
    assign ovf    = n_full >= (d_full << QB);

    logic          ge;
    logic [RW-1:0] rem_n;
    logic [QB-1:0] q_n;

    assign ge    = rem >= dsh;
    assign rem_n = ge ? rem - dsh : rem;
    assign q_n   = {q[QB-2:0], ge};

    function automatic logic [XW:0] finalize(input logic [QB-1:0] qv, input logic ng,
                                             input logic ov);
        logic [XW:0]   rm;
        logic [XW-1:0] mx;
`ifdef MAC1D_INV_ROUND_EN
        rm = {1'b0, qv[QB-1:1]} + {{XW{1'b0}}, qv[0]};
`else
        rm = {1'b0, qv};
`endif
        // Negative magnitude of exactly 2^(XW-1) is representable, so it is not clipped.
        if (ov || (!ng && rm > PLIM) || (ng && rm > HALF)) begin
            finalize = {1'b1, ng ? XMIN : XMAX};
        end else begin
            mx = rm[XW-1:0];
            finalize = {1'b0, ng ? -mx : mx};
        end
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= IDLE;
            rdy   <= 1'b0;
            ovld  <= 1'b0;
            x_r   <= '0;
            dz_r  <= 1'b0;
            sat_r <= 1'b0;
            m_r   <= '0;
            b_r   <= '0;
            y_r   <= '0;
            rem   <= '0;
            dsh   <= '0;
            q     <= '0;
            cnt   <= '0;
            neg_r <= 1'b0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid && rdy) begin
                        m_r   <= bus.m;
                        b_r   <= bus.b;
                        y_r   <= bus.y;
                        rdy   <= 1'b0;
                        state <= LOAD;
                    end else begin
                        rdy <= 1'b1;
                    end
                end
                LOAD: begin
                    if (m_r == '0) begin
                        dz_r  <= 1'b1;
                        sat_r <= (diff != '0);
                        x_r   <= (diff == '0) ? '0 : (diff[DW-1] ? XMIN : XMAX);
                        ovld  <= 1'b1;
                        state <= DONE;
                    end else begin
                        rem   <= n_full;
                        dsh   <= d_full << (QB - 1);
                        ovf_r <= ovf;
                        neg_r <= diff[DW-1] ^ m_r[MW-1];
                        q     <= '0;
                        cnt   <= '0;
                        state <= DIV;
                    end
                end
                DIV: begin
                    rem <= rem_n;
                    dsh <= dsh >> 1;
                    q   <= q_n;
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(QB - 1)) begin
                        {sat_r, x_r} <= finalize(q_n, neg_r, ovf_r);
                        dz_r  <= 1'b0;
                        ovld  <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        ovld  <= 1'b0;
                        rdy   <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = rdy;
    assign bus.out_valid   = ovld;
    assign bus.x           = x_r;
    assign bus.div_by_zero = dz_r;
    assign bus.saturated   = sat_r;
endmodule
